// File: rtl/fixed_lut_denorm.sv
// fixed_lut_denorm: rebuilds a LUT-normalised value (implicit leading 1 plus index)
// and de-normalises it by the MSB position; define FIXED_LUT_DENORM_ROUND_EN for round-half-up.
module fixed_lut_denorm #(
  parameter int WIDTH   = 16,
  parameter int LUT_POW = 5,
  localparam int MSB_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LUT_POW-1:0]   data_in_0,
  input  logic [MSB_WIDTH-1:0] data_in_1,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_out_sat,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam logic [MSB_WIDTH:0]   MSB_MAX   = (MSB_WIDTH + 1)'(WIDTH - 1);
  localparam logic [MSB_WIDTH-1:0] MSB_TOP   = MSB_WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     LEAD_ONE  = WIDTH'(1'b1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0]     LSB_ONE   = WIDTH'(1'b1);

  // Index is left-aligned just below the implicit leading 1; surplus low index bits fall off.
  function automatic logic [WIDTH-1:0] form_mantissa(input logic [LUT_POW-1:0] idx);
    return WIDTH'({idx, {WIDTH{1'b0}}} >> (LUT_POW + 1)) | LEAD_ONE;
  endfunction

  logic                 s1_valid_r;
  logic [WIDTH-1:0]     s1_m_r;
  logic [MSB_WIDTH-1:0] s1_msb_r;
  logic                 s1_load_s;
  logic                 s2_load_s;
  logic [MSB_WIDTH-1:0] shamt_s;
  logic [WIDTH-1:0]     s2_data_s;
  logic                 s2_sat_s;
`ifdef FIXED_LUT_DENORM_ROUND_EN
  logic                 round_s;
`endif

  assign s2_load_s     = !data_out_valid || data_out_ready;
  assign s1_load_s     = !s1_valid_r || s2_load_s;
  assign data_in_ready = !rst && s1_load_s;

  // Stage 2 datapath: saturate out-of-range positions, otherwise shift down (optionally rounding).
  always_comb begin
    shamt_s   = '0;
    s2_data_s = '0;
    s2_sat_s  = 1'b0;
`ifdef FIXED_LUT_DENORM_ROUND_EN
    round_s   = 1'b0;
`endif
    if ({1'b0, s1_msb_r} > MSB_MAX) begin
      s2_data_s = '1;
      s2_sat_s  = 1'b1;
    end else begin
      shamt_s   = MSB_TOP - s1_msb_r;
      s2_data_s = s1_m_r >> shamt_s;
`ifdef FIXED_LUT_DENORM_ROUND_EN
      // The shifted value is below 2^(WIDTH-1) whenever a bit was dropped, so this cannot wrap.
      if (shamt_s != '0) begin
        round_s   = |(s1_m_r & (LSB_ONE << (shamt_s - MSB_WIDTH'(1))));
        s2_data_s = s2_data_s + WIDTH'(round_s);
      end else begin
        round_s   = 1'b0;
      end
`endif
    end
  end

  // Stage 1 register: loads when empty or when its beat moves into stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_m_r     <= '0;
      s1_msb_r   <= '0;
    end else if (s1_load_s) begin
      s1_valid_r <= data_in_valid;
      if (data_in_valid) begin
        s1_m_r   <= form_mantissa(data_in_0);
        s1_msb_r <= data_in_1;
      end
    end
  end

  // Stage 2 / output register: holds while downstream stalls a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
      data_out_sat   <= 1'b0;
    end else if (s2_load_s) begin
      data_out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        data_out     <= s2_data_s;
        data_out_sat <= s2_sat_s;
      end
    end
  end

endmodule

// File: tb/tb_fixed_lut_denorm.sv
// Self-checking bench for fixed_lut_denorm: directed vector table, stall/reset sequences,
// and a randomised valid/ready run checked against a scoreboard model.
module tb_fixed_lut_denorm;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_idx;
  logic [3:0]  in_msb;
  logic        in_valid;
  logic        in_ready_a, in_ready_b;
  logic        out_ready;
  logic [15:0] out_a;
  logic        sat_a, vld_a;
  logic [11:0] out_b;
  logic        sat_b, vld_b;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  logic [16:0] sb_q[$];

  always #5 clk = ~clk;

  fixed_lut_denorm #(.WIDTH(16), .LUT_POW(5)) dut_a (
    .clk(clk), .rst(rst), .data_in_0(in_idx), .data_in_1(in_msb),
    .data_in_valid(in_valid), .data_in_ready(in_ready_a),
    .data_out(out_a), .data_out_sat(sat_a), .data_out_valid(vld_a),
    .data_out_ready(out_ready)
  );

  fixed_lut_denorm #(.WIDTH(12), .LUT_POW(5)) dut_b (
    .clk(clk), .rst(rst), .data_in_0(in_idx), .data_in_1(in_msb),
    .data_in_valid(in_valid), .data_in_ready(in_ready_b),
    .data_out(out_b), .data_out_sat(sat_b), .data_out_valid(vld_b),
    .data_out_ready(out_ready)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [3:0]  msb;
    logic        dut12;
    logic [15:0] exp_trunc;
    logic [15:0] exp_round;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Reference model for the 16-bit instance: {sat, data}, rounding as floor(x + 0.5).
  function automatic logic [16:0] model16(input int idx, input int msb);
    longint m;
    longint r;
    int s;
    m = (longint'(1) << 15) + ((longint'(idx) << 15) >> 5);
    if (msb > 15) return {1'b1, 16'hFFFF};
    s = 15 - msb;
    r = m >> s;
`ifdef FIXED_LUT_DENORM_ROUND_EN
    if (s > 0) r = (m + (longint'(1) << (s - 1))) >> s;
`endif
    return {1'b0, r[15:0]};
  endfunction

  // Scoreboard: pop/compare on each output handshake, push model result on each input handshake.
  always @(negedge clk) begin
    logic [16:0] exp_v;
    if (!rst && vld_a && out_ready) begin
      out_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got output 0x%0h expected none", out_a);
      end else begin
        exp_v = sb_q.pop_front();
        check("sb_data", {16'h0, out_a}, {16'h0, exp_v[15:0]});
        check("sb_sat", {31'h0, sat_a}, {31'h0, exp_v[16]});
      end
    end
    if (!rst && in_valid && in_ready_a) begin
      sb_q.push_back(model16(int'(in_idx), int'(in_msb)));
      acc_cnt++;
    end
  end

  task automatic run_vec(input vec_t v);
    int lat;
    logic [15:0] want;
`ifdef FIXED_LUT_DENORM_ROUND_EN
    want = v.exp_round;
`else
    want = v.exp_trunc;
`endif
    @(posedge clk); #1;
    in_idx = v.idx; in_msb = v.msb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!(v.dut12 ? vld_b : vld_a) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("vec_latency", lat, 2);
    if (v.dut12) begin
      check("vec_data_w12", {20'h0, out_b}, {16'h0, want});
      check("vec_sat_w12", {31'h0, sat_b}, {31'h0, v.exp_sat});
    end else begin
      check("vec_data_w16", {16'h0, out_a}, {16'h0, want});
      check("vec_sat_w16", {31'h0, sat_a}, {31'h0, v.exp_sat});
    end
  endtask

  initial begin
    int acc0, o0, cyc;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, o0, cyc;
    vecs[0]  = '{5'd16, 4'd15, 1'b0, 16'hC000, 16'hC000, 1'b0};
    vecs[1]  = '{5'd16, 4'd3,  1'b0, 16'h000C, 16'h000C, 1'b0};
    vecs[2]  = '{5'd31, 4'd0,  1'b0, 16'h0001, 16'h0002, 1'b0};
    vecs[3]  = '{5'd0,  4'd15, 1'b0, 16'h8000, 16'h8000, 1'b0};
    vecs[4]  = '{5'd0,  4'd0,  1'b0, 16'h0001, 16'h0001, 1'b0};
    vecs[5]  = '{5'd31, 4'd15, 1'b0, 16'hFC00, 16'hFC00, 1'b0};
    vecs[6]  = '{5'd1,  4'd14, 1'b0, 16'h4200, 16'h4200, 1'b0};
    vecs[7]  = '{5'd31, 4'd1,  1'b0, 16'h0003, 16'h0004, 1'b0};
    vecs[8]  = '{5'd7,  4'd8,  1'b0, 16'h0138, 16'h0138, 1'b0};
    vecs[9]  = '{5'd21, 4'd10, 1'b0, 16'h06A0, 16'h06A0, 1'b0};
    vecs[10] = '{5'd16, 4'd13, 1'b1, 16'h0FFF, 16'h0FFF, 1'b1};
    vecs[11] = '{5'd5,  4'd15, 1'b1, 16'h0FFF, 16'h0FFF, 1'b1};
    vecs[12] = '{5'd16, 4'd12, 1'b1, 16'h0FFF, 16'h0FFF, 1'b1};
    vecs[13] = '{5'd16, 4'd11, 1'b1, 16'h0C00, 16'h0C00, 1'b0};
    vecs[14] = '{5'd1,  4'd4,  1'b1, 16'h0010, 16'h0011, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_idx = 5'd0; in_msb = 4'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, vld_a}, 32'h0);
    check("rst_data", {16'h0, out_a}, 32'h0);
    check("rst_sat", {31'h0, sat_a}, 32'h0);
    check("rst_ready", {31'h0, in_ready_a}, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'h0, in_ready_a}, 32'h1);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Back-to-back inputs with output stalled: two beats fit, then ready drops.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    acc0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      in_idx = 5'(i * 3 + 1); in_msb = 4'(15 - i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_accepted", acc_cnt - acc0, 2);
    check("stall_ready_low", {31'h0, in_ready_a}, 32'h0);
    check("stall_out_valid", {31'h0, vld_a}, 32'h1);
    check("stall_data", {16'h0, out_a}, 32'h8400);
    @(posedge clk); #1;
    check("stall_hold", {16'h0, out_a}, 32'h8400);
    out_ready = 1'b1;
    o0 = out_cnt; cyc = 0;
    while (sb_q.size() != 0 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    check("stall_drain_count", out_cnt - o0, 2);

    // Reset while both stages hold beats.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_idx = 5'd9; in_msb = 4'd7;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    check("prerst_ready_low", {31'h0, in_ready_a}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", {31'h0, vld_a}, 32'h0);
    check("midrst_data", {16'h0, out_a}, 32'h0);
    check("midrst_ready", {31'h0, in_ready_a}, 32'h0);
    sb_q.delete();
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    run_vec(vecs[1]);

    // Random valid/ready traffic against the scoreboard.
    acc0 = acc_cnt; cyc = 0;
    while (acc_cnt - acc0 < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_idx    = 5'($urandom_range(0, 31));
      in_msb    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("random_beats", {31'h0, (acc_cnt - acc0) >= 1000}, 32'h1);
    check("random_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
